// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, reset PC, instruction size, opcode field.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_BYTES       = 4;

    // Opcode field position, shared with the main decoder.
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [31:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// Latency: a pushed entry is visible at head_data the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports: clk/rst (sync, active-high); flush empties the queue (wins over push);
//        push/push_data write the tail; pop removes the head;
//        head_data/empty/full/count describe the current contents.
// DEPTH must be a power of two (pointers wrap naturally).
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem requests, 2-entry instruction queue to decode.
// Latency: 2 cycles request-to-decode with a 1-cycle memory response.
// Backpressure: credit-based issue (occupancy + outstanding < Q_DEPTH); out_valid/out_ready to decode.
//
// Ports: clk, rst (sync, active-high);
//        imem_req_valid/ready/addr   - fetch request channel (addr word aligned);
//        imem_resp_valid/data        - in-order response words;
//        redirect_valid/redirect_pc  - path change from execute (flushes wrong-path words);
//        out_valid/ready/inst/pc/opcode - instruction to decode;
//        stall_cnt                   - only when FETCH_STALL_CNT_EN is defined: RUN cycles with
//                                      nothing to offer decode, redirect cycles excluded.
module fetch_unit
    import core_pkg::*;
#(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    Q_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [PC_WIDTH-1:0]  imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [31:0]          imem_resp_data,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [6:0]           out_opcode
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int CW = $clog2(Q_DEPTH+1);
    localparam int EW = 32 + PC_WIDTH;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INST_BYTES - 1);

    fetch_state_e          state;
    fetch_state_e          state_nxt;
    logic [PC_WIDTH-1:0]   fetch_pc;

    logic                  req_hs;
    logic                  resp_take;
    logic                  credit_ok;
    logic [CW:0]           outst_nxt;

    // PC tag FIFO: one entry per in-flight request, so its count is the outstanding count.
    logic [PC_WIDTH-1:0]   tag_head;
    logic                  tag_empty;
    logic                  tag_full;
    logic [CW-1:0]         outst;

    logic                  dq_push;
    logic                  dq_pop;
    logic [EW-1:0]         dq_head;
    logic                  dq_empty;
    logic                  dq_full;
    logic [CW-1:0]         occ;

    assign credit_ok      = ({1'b0, occ} + {1'b0, outst}) < (CW+1)'(Q_DEPTH);
    assign imem_req_valid = (state == FS_RUN) && credit_ok && !rst;
    assign imem_req_addr  = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take = imem_resp_valid && !tag_empty;
    assign outst_nxt = {1'b0, outst} + (CW+1)'(req_hs) - (CW+1)'(resp_take);

    // Only right-path responses reach the queue: not while flushing, not in a redirect cycle.
    assign dq_push = resp_take && (state == FS_RUN) && !redirect_valid;
    assign dq_pop  = out_valid && out_ready;

    fetch_queue #(
        .WIDTH (PC_WIDTH),
        .DEPTH (Q_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_hs),
        .push_data (fetch_pc),
        .pop       (resp_take),
        .head_data (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (outst)
    );

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (Q_DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (dq_push),
        .push_data ({imem_resp_data, tag_head}),
        .pop       (dq_pop),
        .head_data (dq_head),
        .empty     (dq_empty),
        .full      (dq_full),
        .count     (occ)
    );

    assign out_valid  = !dq_empty && !redirect_valid;
    assign out_inst   = dq_empty ? 32'd0 : dq_head[EW-1:PC_WIDTH];
    assign out_pc     = dq_empty ? '0 : dq_head[PC_WIDTH-1:0];
    assign out_opcode = opcode_of(out_inst);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ALIGN_MASK;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN_MASK;
        end else if (req_hs) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(INST_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FS_RUN;
        else     state <= state_nxt;
    end

    // Stay in FLUSH while wrong-path responses are still due; a redirect handshake
    // in the same cycle is already included in outst_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            FS_RUN: begin
                if (redirect_valid && (outst_nxt != '0)) state_nxt = FS_FLUSH;
            end
            FS_FLUSH: begin
                if (outst_nxt == '0) state_nxt = FS_RUN;
            end
            default: state_nxt = FS_RUN;
        endcase
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if ((state == FS_RUN) && !out_valid && !redirect_valid) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    a_resp_with_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> !tag_empty);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        req_hs |-> !tag_full);
    a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        dq_push |-> (!dq_full || dq_pop));

endmodule
